// File: rtl/mem_err_logger.sv
// Memory-test error logger: captures failing compares into a FIFO log,
// keeps a saturating error count and a sticky overflow flag, and reports
// the PASS/FAIL verdict when the test controller signals finish.
module mem_err_logger #(
    parameter int DEPTH = 8,
    parameter int AW    = 15,
    parameter int DW    = 16,
    parameter int PW    = 3,
    parameter int CW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          finish,
    input  logic          err_valid,
    input  logic [AW-1:0] err_addr,
    input  logic [DW-1:0] err_exp,
    input  logic [DW-1:0] err_got,
    input  logic [PW-1:0] err_pass,
    input  logic          rd_en,
    output logic          rd_valid,
    output logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_exp,
    output logic [DW-1:0] rd_got,
    output logic [PW-1:0] rd_pass,
    output logic [CW-1:0] err_count,
    output logic          overflow,
    output logic          log_empty,
    output logic          log_full,
    output logic [1:0]    status
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]  OCC_FULL  = (PTR_W+1)'(DEPTH);
    localparam logic [CW-1:0]   COUNT_MAX = {CW{1'b1}};

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] exp;
        logic [DW-1:0] got;
        logic [PW-1:0] pass;
    } rec_t;

    // Encodings equal the externally visible status code.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    state_t           state;
    rec_t             mem [DEPTH];
    rec_t             rd_rec;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   occ;

    logic             capture;
    logic             do_pop;
    logic             do_push;
    logic             drop;
    logic [CW-1:0]    count_next;
    logic [PTR_W:0]   occ_next;

    // Per-cycle decode of capture, pop/push and next counter values.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        capture    = 1'b0;
        do_pop     = 1'b0;
        do_push    = 1'b0;
        drop       = 1'b0;
        count_next = err_count;
        occ_next   = occ;

        // start clears everything, so nothing else happens in that cycle.
        if (!start) begin
            capture = (state == ST_RUN) && err_valid;
            do_pop  = rd_en && (occ != '0);
            // A simultaneous pop frees the slot for a write into a full log.
            do_push = capture && ((occ != OCC_FULL) || do_pop);
            drop    = capture && !do_push;
        end

        if (capture && (err_count != COUNT_MAX))
            count_next = err_count + CW'(1);

        if (do_push && !do_pop)
            occ_next = occ + (PTR_W+1)'(1);
        else if (do_pop && !do_push)
            occ_next = occ - (PTR_W+1)'(1);
    end

    // Log storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the log array has no reset; validity is tracked by the pointers and occupancy.
        if (do_push)
            mem[wr_ptr] <= rec_t'{addr: err_addr, exp: err_exp, got: err_got, pass: err_pass};
    end

    // Control FSM, pointers, counters and registered read port.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            log_empty <= 1'b1;
            log_full  <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
            rd_rec    <= '0;
        end else if (start) begin
            state     <= ST_RUN;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            log_empty <= 1'b1;
            log_full  <= 1'b0;
            err_count <= '0;
            overflow  <= 1'b0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= do_pop;
            if (do_pop) begin
                rd_rec <= mem[rd_ptr];
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push)
                wr_ptr <= wr_ptr + PTR_W'(1);

            occ       <= occ_next;
            log_empty <= (occ_next == '0);
            log_full  <= (occ_next == OCC_FULL);
            err_count <= count_next;
            if (drop)
                overflow <= 1'b1;

            // The verdict includes an error captured in the finish cycle.
            case (state)
                ST_RUN:  if (finish) state <= (count_next == '0) ? ST_PASS : ST_FAIL;
                default: state <= state;
            endcase
        end
    end

    assign status  = state;
    assign rd_addr = rd_rec.addr;
    assign rd_exp  = rd_rec.exp;
    assign rd_got  = rd_rec.got;
    assign rd_pass = rd_rec.pass;

endmodule

// File: tb/tb_mem_err_logger.sv
// Self-checking bench for mem_err_logger: directed scenarios followed by
// randomized traffic, all checked every cycle against a queue-based model.
module tb_mem_err_logger;

    localparam int DEPTH = 8;
    localparam int AW    = 15;
    localparam int DW    = 16;
    localparam int PW    = 3;
    localparam int CW    = 16;
    localparam int RW    = AW + DW + DW + PW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          finish;
    logic          err_valid;
    logic [AW-1:0] err_addr;
    logic [DW-1:0] err_exp;
    logic [DW-1:0] err_got;
    logic [PW-1:0] err_pass;
    logic          rd_en;
    logic          rd_valid;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_exp;
    logic [DW-1:0] rd_got;
    logic [PW-1:0] rd_pass;
    logic [CW-1:0] err_count;
    logic          overflow;
    logic          log_empty;
    logic          log_full;
    logic [1:0]    status;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model state.
    logic [RW-1:0] m_q [$];
    int            m_cnt;
    bit            m_ov;
    bit            m_rv;
    logic [RW-1:0] m_rrec;
    int            m_st;     // 0 IDLE, 1 RUN, 2 PASS, 3 FAIL

    mem_err_logger #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .PW(PW), .CW(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .err_valid(err_valid), .err_addr(err_addr), .err_exp(err_exp),
        .err_got(err_got), .err_pass(err_pass), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_exp(rd_exp),
        .rd_got(rd_got), .rd_pass(rd_pass), .err_count(err_count),
        .overflow(overflow), .log_empty(log_empty), .log_full(log_full),
        .status(status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        bit pop, cap;
        if (!rst) begin
            m_q.delete(); m_cnt = 0; m_ov = 0; m_rv = 0; m_rrec = '0; m_st = 0;
        end else if (start) begin
            m_q.delete(); m_cnt = 0; m_ov = 0; m_rv = 0; m_st = 1;
        end else begin
            pop = rd_en && (m_q.size() > 0);
            cap = (m_st == 1) && err_valid;
            m_rv = pop;
            if (pop) m_rrec = m_q.pop_front();
            if (cap) begin
                if (m_cnt < (1 << CW) - 1) m_cnt++;
                if (m_q.size() < DEPTH) m_q.push_back({err_addr, err_exp, err_got, err_pass});
                else m_ov = 1;
            end
            if ((m_st == 1) && finish) m_st = (m_cnt == 0) ? 2 : 3;
        end
    endtask

    // One clock: update model, clock the DUT, compare all outputs, release pulses.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("status",    64'(status),    64'(m_st));
        check("err_count", 64'(err_count), 64'(m_cnt));
        check("overflow",  64'(overflow),  64'(m_ov));
        check("log_empty", 64'(log_empty), 64'(m_q.size() == 0));
        check("log_full",  64'(log_full),  64'(m_q.size() == DEPTH));
        check("rd_valid",  64'(rd_valid),  64'(m_rv));
        check("rd_rec",    64'({rd_addr, rd_exp, rd_got, rd_pass}), 64'(m_rrec));
        start = 0; finish = 0; err_valid = 0; rd_en = 0;
    endtask

    task automatic set_err(input logic [AW-1:0] a, input logic [DW-1:0] e,
                           input logic [DW-1:0] g, input logic [PW-1:0] p);
        err_valid = 1; err_addr = a; err_exp = e; err_got = g; err_pass = p;
    endtask

    task automatic rand_err();
        set_err(AW'($urandom), DW'($urandom), DW'($urandom), PW'($urandom));
    endtask

    initial begin
        rst = 0; start = 0; finish = 0; rd_en = 0;
        err_valid = 0; err_addr = '0; err_exp = '0; err_got = '0; err_pass = '0;
        #2;
        tick(); tick();
        rst = 1;
        tick();

        // Clean run: PASS verdict, empty log.
        start = 1; tick();
        repeat (20) tick();
        finish = 1; tick();
        check("t1_pass", 64'(status), 64'(2'b10));

        // Two errors, verdict FAIL, drain both in order.
        start = 1; tick();
        set_err(15'h0005, 16'hAAAA, 16'hAAAB, 3'd1); tick();
        set_err(15'h7FFF, 16'h1234, 16'h1230, 3'd2); tick();
        finish = 1; tick();
        check("t2_fail", 64'(status), 64'(2'b11));
        rd_en = 1; tick();
        check("t2_rec0", 64'({rd_addr, rd_exp, rd_got, rd_pass}),
              64'({15'h0005, 16'hAAAA, 16'hAAAB, 3'd1}));
        rd_en = 1; tick();
        check("t2_rec1_addr", 64'(rd_addr), 64'(15'h7FFF));
        tick();

        // Overflow: DEPTH+3 errors, then drain everything.
        start = 1; tick();
        repeat (DEPTH + 3) begin rand_err(); tick(); end
        check("t3_count", 64'(err_count), 64'(DEPTH + 3));
        check("t3_ovf", 64'(overflow), 64'(1));
        repeat (DEPTH) begin rd_en = 1; tick(); end
        check("t3_empty", 64'(log_empty), 64'(1));
        rd_en = 1; tick();

        // Full log with simultaneous write and pop: accepted, no overflow.
        start = 1; tick();
        repeat (DEPTH) begin rand_err(); tick(); end
        rand_err(); rd_en = 1; tick();
        check("t4_ovf", 64'(overflow), 64'(0));
        check("t4_full", 64'(log_full), 64'(1));

        // Errors and reads in IDLE.
        rst = 0; tick(); rst = 1;
        rand_err(); rd_en = 1; tick();
        check("t5_count", 64'(err_count), 64'(0));
        check("t5_rv", 64'(rd_valid), 64'(0));

        // Reset mid-run with entries logged.
        start = 1; tick();
        repeat (3) begin rand_err(); tick(); end
        rst = 0; tick(); rst = 1;
        check("t6_status", 64'(status), 64'(0));
        tick();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            rst    = ($urandom_range(999) >= 4);
            start  = ($urandom_range(99) < 3);
            finish = ($urandom_range(99) < 3);
            rd_en  = ($urandom_range(99) < 30);
            if ($urandom_range(99) < 45) rand_err();
            tick();
            rst = 1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
